var_access: RTL and testbench

VAR_ACCESS -- requirements
Module: var_access

---
 rtl/var_access_if.sv | 34 +++
 rtl/var_access.sv | 154 +++++++++++++++
 tb/tb_var_access.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/var_access_if.sv
// rtl/var_access_if.sv - address type package and byte-wide memory bus interface
package register_types;
    localparam int ADDR_W = 16;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

interface var_access_if;
    import register_types::*;

    logic       mem_req;
    addr_t      mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/var_access.sv
// rtl/var_access.sv - 16-bit variable load/store over a byte memory bus (stack, local, global)
module var_access
    import register_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         write,
    input  logic [7:0]   V,
    input  logic [15:0]  wdata,
    input  addr_t        FP,
    input  addr_t        GP,
    input  addr_t        SP,
    output logic [15:0]  rdata,
    output logic         busy,
    output logic         done,
    output addr_t        sp_out,
    output logic         sp_we,
    var_access_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    addr_t       addr_q;
    addr_t       sp_new_q;
    logic        write_q;
    logic        vzero_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;

    addr_t       a_calc;
    addr_t       sp_calc;

    // Word address from the live inputs; only sampled when a start is accepted.
    always_comb begin
        a_calc  = '0;
        sp_calc = '0;
        if (V == 8'h00) begin
            if (write) begin
                a_calc  = SP;
                sp_calc = SP + addr_t'(2);
            end else begin
                a_calc  = SP - addr_t'(2);
                sp_calc = SP - addr_t'(2);
            end
        end else if (V < 8'h10) begin
            a_calc = FP + addr_t'(2) + (addr_t'(V) << 1);
        end else begin
            a_calc = GP + (addr_t'(V - 8'h10) << 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from state so reset zeroes them without waiting for a clock.
    always_comb begin
        state_d       = state_q;
        mem.mem_req   = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        busy          = 1'b1;
        done          = 1'b0;
        sp_we         = 1'b0;
        sp_out        = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = HI;
                end
            end
            HI: begin
                mem.mem_req   = 1'b1;
                mem.mem_addr  = addr_q;
                mem.mem_we    = write_q;
                mem.mem_wdata = wdata_q[15:8];
                if (mem.mem_ack) begin
                    state_d = LO;
                end
            end
            LO: begin
                mem.mem_req   = 1'b1;
                mem.mem_addr  = addr_q + addr_t'(1);
                mem.mem_we    = write_q;
                mem.mem_wdata = wdata_q[7:0];
                if (mem.mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                sp_we   = vzero_q;
                sp_out  = vzero_q ? sp_new_q : '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            sp_new_q <= '0;
            write_q  <= 1'b0;
            vzero_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= a_calc;
                        sp_new_q <= sp_calc;
                        write_q  <= write;
                        vzero_q  <= (V == 8'h00);
                        wdata_q  <= wdata;
                    end
                end
                HI: begin
                    if (mem.mem_ack && !write_q) begin
                        rdata_q[15:8] <= mem.mem_rdata;
                    end
                end
                LO: begin
                    if (mem.mem_ack && !write_q) begin
                        rdata_q[7:0] <= mem.mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_var_access.sv
// tb/tb_var_access.sv - directed self-checking bench for var_access
module tb_var_access;
    import register_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  V = 8'h00;
    logic [15:0] wdata = 16'h0000;
    addr_t       FP = '0;
    addr_t       GP = '0;
    addr_t       SP = '0;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    addr_t       sp_out;
    logic        sp_we;

    var_access_if mbus();

    var_access dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .write  (write),
        .V      (V),
        .wdata  (wdata),
        .FP     (FP),
        .GP     (GP),
        .SP     (SP),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .sp_out (sp_out),
        .sp_we  (sp_we),
        .mem    (mbus.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Byte memory model with a programmable ack delay.
    logic [7:0]  memory [0:65535];
    logic [24:0] log_q [$];
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        ack_force = 1'b0;
    logic        pk_en = 1'b0;
    addr_t       pk_addr = '0;
    logic [7:0]  pk_data = 8'h00;
    int          done_cnt = 0;
    int          spwe_cnt = 0;

    assign mbus.mem_ack   = ack_force | (mbus.mem_req && (wcnt == ack_delay));
    assign mbus.mem_rdata = memory[mbus.mem_addr];

    always @(posedge clk) begin
        if (pk_en) begin
            memory[pk_addr] = pk_data;
        end
        if (mbus.mem_req && mbus.mem_ack) begin
            log_q.push_back({mbus.mem_we, mbus.mem_addr,
                             mbus.mem_we ? mbus.mem_wdata : mbus.mem_rdata});
            if (mbus.mem_we) begin
                memory[mbus.mem_addr] = mbus.mem_wdata;
            end
        end
        if (!mbus.mem_req || mbus.mem_ack) wcnt = 0;
        else wcnt = wcnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (sp_we) spwe_cnt = spwe_cnt + 1;
    end

    logic        stab_on = 1'b0;
    logic        hold_prev = 1'b0;
    logic [24:0] prev_bus = '0;
    int          stab_cnt = 0;
    int          stab_err = 0;

    always @(negedge clk) begin
        if (stab_on && hold_prev && mbus.mem_req) begin
            stab_cnt = stab_cnt + 1;
            if ({mbus.mem_we, mbus.mem_addr, mbus.mem_wdata} !== prev_bus) stab_err = stab_err + 1;
        end
        hold_prev = mbus.mem_req && !mbus.mem_ack;
        prev_bus  = {mbus.mem_we, mbus.mem_addr, mbus.mem_wdata};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input addr_t a, input logic [7:0] d);
        pk_addr = a;
        pk_data = d;
        pk_en   = 1'b1;
        @(negedge clk);
        pk_en   = 1'b0;
    endtask

    // Called at a negedge; returns the cycle count from start to the done cycle.
    task automatic run_op(input logic [7:0] v, input logic wr, input logic [15:0] wd,
                          input addr_t fp, input addr_t gp, input addr_t sp,
                          input bit extra_start, output int lat);
        V = v; write = wr; wdata = wd; FP = fp; GP = gp; SP = sp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        V = ~v; write = ~wr; wdata = ~wd;
        FP = fp + 16'h1111; GP = gp + 16'h2222; SP = sp + 16'h3333;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        while (!done && lat < 50) begin
            @(negedge clk);
            lat = lat + 1;
            start = (extra_start && !done) ? lat[0] : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input logic we,
                             input addr_t a, input logic [7:0] d);
        logic [24:0] ent;
        ent = (idx < log_q.size()) ? log_q[idx] : 25'h1ffffff;
        check(tag, {7'b0, ent}, {7'b0, we, a, d});
    endtask

    int lat;
    int base;
    int dc0;
    int sc0;
    int guard;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ctrl", {27'b0, busy, done, sp_we, mbus.mem_req, mbus.mem_we}, 32'd0);
        check("rst_addr", {16'b0, mbus.mem_addr}, 32'd0);
        check("rst_data", {8'b0, mbus.mem_wdata, rdata}, 32'd0);
        check("rst_spout", {16'b0, sp_out}, 32'd0);
        rst_n = 1'b1;

        // Stray ack while idle
        base = log_q.size();
        dc0 = done_cnt;
        ack_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ack_force = 1'b0;
        check("idle_ack_busy", {31'b0, busy}, 32'd0);
        check("idle_ack_nolog", log_q.size() - base, 32'd0);
        check("idle_ack_nodone", done_cnt - dc0, 32'd0);

        // Local load
        poke(16'h0108, 8'h12);
        poke(16'h0109, 8'h34);
        base = log_q.size();
        run_op(8'h03, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 1'b0, lat);
        check("local_lat", lat, 32'd3);
        check("local_rdata", {16'b0, rdata}, 32'h1234);
        check("local_spwe", {31'b0, sp_we}, 32'd0);
        check("local_nlog", log_q.size() - base, 32'd2);
        check_log("local_hi", base, 1'b0, 16'h0108, 8'h12);
        check_log("local_lo", base + 1, 1'b0, 16'h0109, 8'h34);
        @(negedge clk);
        check("done_pulse", {30'b0, done, busy}, 32'd0);

        // Global store
        base = log_q.size();
        run_op(8'h11, 1'b1, 16'hBEEF, 16'h0000, 16'h0200, 16'h0000, 1'b0, lat);
        check("gstore_lat", lat, 32'd3);
        check("gstore_spwe", {31'b0, sp_we}, 32'd0);
        check("gstore_rdata_held", {16'b0, rdata}, 32'h1234);
        check_log("gstore_hi", base, 1'b1, 16'h0202, 8'hBE);
        check_log("gstore_lo", base + 1, 1'b1, 16'h0203, 8'hEF);
        @(negedge clk);

        // Push then pop
        base = log_q.size();
        run_op(8'h00, 1'b1, 16'hA55A, 16'h0000, 16'h0000, 16'h0400, 1'b0, lat);
        check("push_lat", lat, 32'd3);
        check("push_sp", {15'b0, sp_we, sp_out}, {15'b0, 1'b1, 16'h0402});
        check_log("push_hi", base, 1'b1, 16'h0400, 8'hA5);
        check_log("push_lo", base + 1, 1'b1, 16'h0401, 8'h5A);
        @(negedge clk);
        check("push_spwe_drop", {31'b0, sp_we}, 32'd0);
        base = log_q.size();
        run_op(8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0402, 1'b0, lat);
        check("pop_rdata", {16'b0, rdata}, 32'hA55A);
        check("pop_sp", {15'b0, sp_we, sp_out}, {15'b0, 1'b1, 16'h0400});
        check_log("pop_hi", base, 1'b0, 16'h0400, 8'hA5);
        check_log("pop_lo", base + 1, 1'b0, 16'h0401, 8'h5A);
        @(negedge clk);

        // Stalled memory with extra starts while busy
        poke(16'h0304, 8'hC3);
        poke(16'h0305, 8'h3C);
        ack_delay = 3;
        stab_on = 1'b1;
        base = log_q.size();
        run_op(8'h01, 1'b0, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 1'b1, lat);
        stab_on = 1'b0;
        check("stall_lat", lat, 32'd9);
        check("stall_rdata", {16'b0, rdata}, 32'hC33C);
        check("stall_nlog", log_q.size() - base, 32'd2);
        check_log("stall_hi", base, 1'b0, 16'h0304, 8'hC3);
        check_log("stall_lo", base + 1, 1'b0, 16'h0305, 8'h3C);
        check("stall_stable_cycles", stab_cnt, 32'd6);
        check("stall_stable_err", stab_err, 32'd0);
        @(negedge clk);
        check("stall_no_restart", {31'b0, busy}, 32'd0);

        // Reset during LO of a push
        ack_delay = 2;
        dc0 = done_cnt;
        sc0 = spwe_cnt;
        V = 8'h00; write = 1'b1; wdata = 16'h1234; SP = 16'h0500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (mbus.mem_addr != 16'h0501 && guard < 20) begin
            @(negedge clk);
            guard = guard + 1;
        end
        check("rst_mid_reached_lo", {15'b0, mbus.mem_req, mbus.mem_addr}, {15'b0, 1'b1, 16'h0501});
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {27'b0, busy, done, sp_we, mbus.mem_req, mbus.mem_we}, 32'd0);
        check("rst_mid_bus", {8'b0, mbus.mem_addr, mbus.mem_wdata}, 32'd0);
        check("rst_mid_out", {sp_out, rdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_no_done", done_cnt - dc0, 32'd0);
        check("rst_mid_no_spwe", spwe_cnt - sc0, 32'd0);
        ack_delay = 0;
        rst_n = 1'b1;
        base = log_q.size();
        run_op(8'h05, 1'b1, 16'hCAFE, 16'h0600, 16'h0000, 16'h0000, 1'b0, lat);
        check("post_rst_lat", lat, 32'd3);
        check_log("post_rst_hi", base, 1'b1, 16'h060C, 8'hCA);
        check_log("post_rst_lo", base + 1, 1'b1, 16'h060D, 8'hFE);
        @(negedge clk);

        // Address wrap
        poke(16'hFFFE, 8'h5A);
        poke(16'hFFFF, 8'hC3);
        base = log_q.size();
        run_op(8'h0F, 1'b0, 16'h0000, 16'hFFDE, 16'h0000, 16'h0000, 1'b0, lat);
        check("wrap_local_rdata", {16'b0, rdata}, 32'h5AC3);
        check_log("wrap_local_hi", base, 1'b0, 16'hFFFE, 8'h5A);
        check_log("wrap_local_lo", base + 1, 1'b0, 16'hFFFF, 8'hC3);
        @(negedge clk);
        base = log_q.size();
        run_op(8'h10, 1'b1, 16'h7788, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, lat);
        check_log("wrap_glob_hi", base, 1'b1, 16'hFFFF, 8'h77);
        check_log("wrap_glob_lo", base + 1, 1'b1, 16'h0000, 8'h88);
        @(negedge clk);
        base = log_q.size();
        run_op(8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, lat);
        check("wrap_pop_rdata", {16'b0, rdata}, 32'h5A77);
        check("wrap_pop_sp", {15'b0, sp_we, sp_out}, {15'b0, 1'b1, 16'hFFFE});
        check_log("wrap_pop_hi", base, 1'b0, 16'hFFFE, 8'h5A);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
